// File: rtl/unidad_corrimiento_serie.sv
// Iterative N-bit shifter: one bit position per clock, start/busy/done handshake.
// Ports: clk, rst_n, start, F, H, D in; busy, done, s, c out. Carry gated by SHIFT_CARRY_EN.
module unidad_corrimiento_serie #(
  parameter int N  = 8,
  parameter int DW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  F,
  input  logic [2:0]    H,
  input  logic [DW-1:0] D,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  s,
  output logic          c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_XFER = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_ZERO = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASL  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  state_t        state_q, state_d;
  logic [N-1:0]  reg_q;
  logic [DW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic [N-1:0]  step_s;
  logic [DW-1:0] cnt_ld;
  logic          accept;

  assign accept = (state_q == IDLE) && start;

  // transfer and zero complete in a single edge, whatever D says
  always_comb begin
    cnt_ld = D;
    if (H == OP_XFER || H == OP_ZERO)
      cnt_ld = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (cnt_ld != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == DW'(1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    step_s = reg_q;
    unique case (op_q)
      OP_SHL, OP_ASL: step_s = {reg_q[N-2:0], 1'b0};
      OP_SHR:         step_s = {1'b0, reg_q[N-1:1]};
      OP_ASR:         step_s = {reg_q[N-1], reg_q[N-1:1]};
      OP_ROL:         step_s = {reg_q[N-2:0], reg_q[N-1]};
      OP_ROR:         step_s = {reg_q[0], reg_q[N-1:1]};
      default:        step_s = reg_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
      cnt_q <= '0;
      op_q  <= OP_XFER;
    end else if (accept) begin
      op_q  <= H;
      reg_q <= (H == OP_ZERO) ? '0 : F;
      cnt_q <= cnt_ld;
    end else if (state_q == SHIFT) begin
      reg_q <= step_s;
      cnt_q <= cnt_q - DW'(1);
    end
  end

  assign s = reg_q;

`ifdef SHIFT_CARRY_EN
  logic step_c;
  logic c_q;

  // left moves expose the MSB, right moves expose the LSB
  always_comb begin
    step_c = 1'b0;
    unique case (op_q)
      OP_SHL, OP_ASL, OP_ROL:  step_c = reg_q[N-1];
      OP_SHR, OP_ASR, OP_ROR:  step_c = reg_q[0];
      default:                 step_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      c_q <= 1'b0;
    else if (accept)
      c_q <= 1'b0;
    else if (state_q == SHIFT)
      c_q <= step_c;
  end

  assign c = c_q;
`else
  assign c = 1'b0;
`endif

endmodule

// File: tb/tb_unidad_corrimiento_serie.sv
// Directed-vector bench for unidad_corrimiento_serie (N=8).
// Checks reset, every op class, latency, handshake and mid-op reset.
module tb_unidad_corrimiento_serie;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] F = '0;
  logic [2:0] H = '0;
  logic [2:0] D = '0;
  logic       busy;
  logic       done;
  logic [7:0] s;
  logic       c;

`ifdef SHIFT_CARRY_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  unidad_corrimiento_serie #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .F     (F),
    .H     (H),
    .D     (D),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] f,
                        input logic [2:0] h,
                        input logic [2:0] d,
                        output int edges);
    @(negedge clk);
    F = f; H = h; D = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    F = ~f; H = ~h; D = ~d;
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic check_op(input string tag,
                          input logic [7:0] f,
                          input logic [2:0] h,
                          input logic [2:0] d,
                          input logic [7:0] exp_s,
                          input logic exp_c,
                          input int exp_edges);
    int e;
    run_op(f, h, d, e);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, e, exp_edges);
    chk({tag, "_s"}, s, exp_s);
    chk({tag, "_c"}, c, CE & exp_c);
    @(posedge clk); #1;
    chk({tag, "_done1"}, done, 0);
    chk({tag, "_busy1"}, busy, 0);
    chk({tag, "_hold"}, s, exp_s);
  endtask

  initial begin
    int e;
    int ndone;
    logic [7:0] cap;

    #12 rst_n = 1'b1;
    #1;
    chk("rst_s", s, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c", c, 0);

    check_op("xfer", 8'hC3, 3'b000, 3'd5, 8'hC3, 1'b0, 1);
    check_op("zero", 8'hC3, 3'b011, 3'd5, 8'h00, 1'b0, 1);
    check_op("rol3", 8'b11000011, 3'b100, 3'd3, 8'b00011110, 1'b0, 4);
    check_op("ror3", 8'b11000011, 3'b101, 3'd3, 8'b01111000, 1'b0, 4);
    check_op("shl7", 8'b00000011, 3'b001, 3'd7, 8'b10000000, 1'b1, 8);
    check_op("asr3", 8'b10010101, 3'b111, 3'd3, 8'b11110010, 1'b1, 4);
    check_op("shr2", 8'b10010110, 3'b010, 3'd2, 8'b00100101, 1'b1, 3);
    check_op("asl1", 8'b01000001, 3'b110, 3'd1, 8'b10000010, 1'b0, 2);
    check_op("ror0", 8'hA7, 3'b101, 3'd0, 8'hA7, 1'b0, 1);

    // mid-cycle async reset clears outputs without a clock edge
    check_op("rolc", 8'h81, 3'b100, 3'd1, 8'h03, 1'b1, 2);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s", s, 0);
    chk("arst_c", c, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // second start while busy is ignored
    @(negedge clk);
    F = 8'b11000011; H = 3'b100; D = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_busy", busy, 1);
    @(negedge clk);
    F = 8'hFF; H = 3'b000; D = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    cap = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        cap = s;
      end
    end
    chk("hs_ndone", ndone, 1);
    chk("hs_s", cap, 8'b00011110);
    chk("hs_idle", busy, 0);

    // reset during a long shift abandons it
    @(negedge clk);
    F = 8'b00000011; H = 3'b001; D = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_s", s, 0);
    chk("mrst_c", c, 0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    check_op("fresh", 8'b10010101, 3'b111, 3'd3, 8'b11110010, 1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/unidad_corrimiento_serie.md
# unidad_corrimiento_serie

Iterative, parametrised N-bit shift unit. It executes the team's eight-operation shift set (transfer, shl, shr, zero, rol, ror, asl, asr) one bit position per clock under a start/busy/done handshake, and reports the last bit shifted out. It sits beside the combinational shift unit in datapaths where area matters more than latency, for example a shared shifter behind a sequencer.

## Interface
- N, default 8: data width; power of two, ≥4.
- DW, default $clog2(N): width of shift amount D (range 0..N-1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- F  in  N  operand; captured on the accepted start.
- H  in  3  operation: 000 transfer, 001 shl, 010 shr, 011 zero, 100 rol, 101 ror, 110 asl (identical to shl), 111 asr (sign fill).
- D  in  DW  shift amount; captured on the accepted start.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; result valid.
- s  out  N  result (working register).
- c  out  1  carry: last bit shifted or rotated out (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE. Registers: state, working reg (drives s), cnt (DW bits), op (3 bits), c.
- IDLE, start=1: op<=H; reg<=F, or 0 for zero; cnt<=D, forced to 0 for transfer and zero; c<=0.
  - cnt load value ≠0 → SHIFT.
  - Otherwise → DONE.
- SHIFT, each edge: apply a one-position op to reg and cnt<=cnt-1. Go to DONE when cnt==1.
  - shl/asl: reg<={reg[N-2:0],0}, c<=reg[N-1].
  - shr: {0,reg[N-1:1]}, c<=reg[0].
  - asr: {reg[N-1],reg[N-1:1]}, c<=reg[0].
  - rol: {reg[N-2:0],reg[N-1]}, c<=reg[N-1].
  - ror: {reg[0],reg[N-1:1]}, c<=reg[0].
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- start in SHIFT or DONE is ignored; the operands in flight are unaffected. F, H and D may change freely after acceptance.
- s and c hold their values from DONE until the next accepted start. Mid-operation s values are intermediate and not defined as results.
- Reset (asynchronous, any state): state=IDLE, s=0, c=0, cnt=0, busy=0, done=0. The operation in progress is abandoned, with no done pulse.

## Timing
- Latency from the start-sampling edge to the done-asserting edge: D+1 edges for shift ops; 1 edge for transfer, zero, and any op with D=0.
- busy rises on the edge that accepts start and falls on the edge leaving DONE.
- The next start is accepted at the earliest in the cycle after done. Back-to-back throughput is therefore one op per D+2 cycles.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- SHIFT_CARRY_EN defined: c behaves as specified above.
- Not defined: c is tied to 0 and its register is removed. All other behaviour is identical.

## Test plan
All scenarios use N=8 with SHIFT_CARRY_EN defined.
- Reset then idle: rst_n=0 mid-cycle → s=0, c=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Transfer and zero: F=8'hC3, H=000 → done after 1 edge, s=8'hC3, c=0. H=011 → done after 1 edge, s=8'h00.
- Shift and rotate, F=8'b11000011, D=3:
  - rol → s=8'b00011110, c=0.
  - ror → s=8'b01111000, c=0.
  - In both cases done is asserted on the 4th edge after start.
- shl and asr:
  - F=8'b00000011, H=001, D=7 → s=8'b10000000, c=1, done after 8 edges.
  - F=8'b10010101, H=111, D=3 → s=8'b11110010, c=1.
- Handshake: pulse start again with new F while busy → ignored; the first result completes unchanged and only one done pulse occurs. D=0 with H=101 → s=F, done after 1 edge.
- Reset mid-operation: assert rst_n=0 during SHIFT of a D=7 op → no done pulse, and state, s and c return to reset values. A fresh start after release completes normally.
